// File: rtl/mips_pkg.sv
// Shared widths, ALU opcodes and EX-stage FSM state encodings for the pipeline.
package mips_pkg;

  localparam int unsigned DATA_W_DEF     = 16;
  localparam int unsigned REG_ADDR_W_DEF = 3;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_OR  = 3'd3;
  localparam logic [2:0] ALU_XOR = 3'd4;
  localparam logic [2:0] ALU_SLL = 3'd5;
  localparam logic [2:0] ALU_SRL = 3'd6;
  localparam logic [2:0] ALU_MUL = 3'd7;

  typedef enum logic [1:0] {
    ExIdle = 2'd0,
    ExMul  = 2'd1,
    ExDone = 2'd2
  } ex_state_e;

endpackage

// File: rtl/ex_mul_seq.sv
// Iterative shift-add multiplier, one partial product per step, low DATA_W bits kept.
module ex_mul_seq #(
  parameter int unsigned DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic              step_i,
  input  logic              abort_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  output logic [DATA_W-1:0] prod_o,
  output logic              last_o
);

  localparam int unsigned CntW = $clog2(DATA_W);
  localparam logic [CntW-1:0] CntLast = CntW'(DATA_W - 1);

  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic [CntW-1:0]   cnt_q, cnt_d;

  always_comb begin
    a_d   = a_q;
    b_d   = b_q;
    acc_d = acc_q;
    cnt_d = cnt_q;
    if (abort_i) begin
      acc_d = '0;
      cnt_d = '0;
    end else if (start_i) begin
      a_d   = a_i;
      b_d   = b_i;
      acc_d = '0;
      cnt_d = '0;
    end else if (step_i) begin
      if (b_q[0]) acc_d = acc_q + a_q;
      a_d   = a_q << 1;
      b_d   = b_q >> 1;
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q   <= '0;
      b_q   <= '0;
      acc_q <= '0;
      cnt_q <= '0;
    end else begin
      a_q   <= a_d;
      b_q   <= b_d;
      acc_q <= acc_d;
      cnt_q <= cnt_d;
    end
  end

  assign prod_o = acc_q;
  // High while the step that completes the product is being taken.
  assign last_o = (cnt_q == CntLast);

endmodule

// File: rtl/ex_stage.sv
// Execute stage: combinational ALU plus EX/MEM register feeding MEM_stage.
// EX_STAGE_MUL_EN adds the iterative multiplier and its stall FSM.
module ex_stage
  import mips_pkg::*;
#(
  parameter int unsigned DATA_W     = DATA_W_DEF,
  parameter int unsigned REG_ADDR_W = REG_ADDR_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_valid,
  input  logic                  id_flush,
  input  logic [2:0]            id_alu_op,
  input  logic [DATA_W-1:0]     id_src_a,
  input  logic [DATA_W-1:0]     id_src_b,
  input  logic [DATA_W-1:0]     id_store_data,
  input  logic [REG_ADDR_W-1:0] id_op_dest,
  input  logic                  id_mem_write_en,
  input  logic                  id_wb_mux,
  input  logic                  id_wb_en,
  output logic [DATA_W-1:0]     ex_alu_res,
  output logic [DATA_W-1:0]     ex_store_data,
  output logic [REG_ADDR_W-1:0] ex_op_dest,
  output logic                  mem_write_en,
  output logic                  ex_wb_mux,
  output logic                  ex_wb_en,
  output logic                  ex_busy
);

  localparam logic [DATA_W-1:0] One = {{(DATA_W-1){1'b0}}, 1'b1};

  logic [DATA_W-1:0] alu_res;
  logic [DATA_W-1:0] wb_res;
  logic              load;

  always_comb begin
    case (id_alu_op)
      ALU_ADD: alu_res = id_src_a + id_src_b;
      ALU_SUB: alu_res = id_src_a + ~id_src_b + One;
      ALU_AND: alu_res = id_src_a & id_src_b;
      ALU_OR:  alu_res = id_src_a | id_src_b;
      ALU_XOR: alu_res = id_src_a ^ id_src_b;
      ALU_SLL: alu_res = id_src_a << id_src_b[3:0];
      ALU_SRL: alu_res = id_src_a >> id_src_b[3:0];
      default: alu_res = '0;
    endcase
  end

`ifdef EX_STAGE_MUL_EN
  ex_state_e         state_q, state_d;
  logic              mul_start;
  logic              mul_step;
  logic              mul_abort;
  logic              mul_last;
  logic [DATA_W-1:0] mul_prod;

  ex_mul_seq #(
    .DATA_W (DATA_W)
  ) u_mul (
    .clk     (clk),
    .rst     (rst),
    .start_i (mul_start),
    .step_i  (mul_step),
    .abort_i (mul_abort),
    .a_i     (id_src_a),
    .b_i     (id_src_b),
    .prod_o  (mul_prod),
    .last_o  (mul_last)
  );

  always_comb begin
    state_d   = state_q;
    ex_busy   = 1'b0;
    mul_start = 1'b0;
    mul_step  = 1'b0;
    mul_abort = 1'b0;
    load      = 1'b0;
    wb_res    = alu_res;
    // Reset overrides the stall so upstream is never held while the stage clears.
    if (!rst) begin
      unique case (state_q)
        ExIdle: begin
          if (id_valid && !id_flush) begin
            if (id_alu_op == ALU_MUL) begin
              mul_start = 1'b1;
              ex_busy   = 1'b1;
              state_d   = ExMul;
            end else begin
              load = 1'b1;
            end
          end
        end
        ExMul: begin
          if (id_flush) begin
            mul_abort = 1'b1;
            state_d   = ExIdle;
          end else begin
            mul_step = 1'b1;
            ex_busy  = 1'b1;
            if (mul_last) state_d = ExDone;
          end
        end
        ExDone: begin
          state_d = ExIdle;
          if (id_flush) begin
            mul_abort = 1'b1;
          end else begin
            load   = 1'b1;
            wb_res = mul_prod;
          end
        end
        default: state_d = ExIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= ExIdle;
    else     state_q <= state_d;
  end
`else
  assign ex_busy = 1'b0;
  assign load    = id_valid & ~id_flush;
  assign wb_res  = alu_res;
`endif

  logic [DATA_W-1:0]     res_q, res_d;
  logic [DATA_W-1:0]     sd_q, sd_d;
  logic [REG_ADDR_W-1:0] dest_q, dest_d;
  logic                  mw_q, mw_d;
  logic                  wbm_q, wbm_d;
  logic                  wbe_q, wbe_d;

  always_comb begin
    res_d  = '0;
    sd_d   = '0;
    dest_d = '0;
    mw_d   = 1'b0;
    wbm_d  = 1'b0;
    wbe_d  = 1'b0;
    if (load) begin
      res_d  = wb_res;
      sd_d   = id_store_data;
      dest_d = id_op_dest;
      mw_d   = id_mem_write_en;
      wbm_d  = id_wb_mux;
      wbe_d  = id_wb_en;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      res_q  <= '0;
      sd_q   <= '0;
      dest_q <= '0;
      mw_q   <= 1'b0;
      wbm_q  <= 1'b0;
      wbe_q  <= 1'b0;
    end else begin
      res_q  <= res_d;
      sd_q   <= sd_d;
      dest_q <= dest_d;
      mw_q   <= mw_d;
      wbm_q  <= wbm_d;
      wbe_q  <= wbe_d;
    end
  end

  assign ex_alu_res    = res_q;
  assign ex_store_data = sd_q;
  assign ex_op_dest    = dest_q;
  assign mem_write_en  = mw_q;
  assign ex_wb_mux     = wbm_q;
  assign ex_wb_en      = wbe_q;

endmodule

// File: tb/tb_ex_stage.sv
// Scoreboard bench for ex_stage: driver queues expected outputs, negedge monitor checks them.
module tb_ex_stage;
  import mips_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        id_valid = 1'b0, id_flush = 1'b0;
  logic [2:0]  id_alu_op = '0;
  logic [15:0] id_src_a = '0, id_src_b = '0, id_store_data = '0;
  logic [2:0]  id_op_dest = '0;
  logic        id_mem_write_en = 1'b0, id_wb_mux = 1'b0, id_wb_en = 1'b0;
  logic [15:0] ex_alu_res, ex_store_data;
  logic [2:0]  ex_op_dest;
  logic        mem_write_en, ex_wb_mux, ex_wb_en, ex_busy;

  ex_stage #(.DATA_W(16), .REG_ADDR_W(3)) dut (
    .clk             (clk),
    .rst             (rst),
    .id_valid        (id_valid),
    .id_flush        (id_flush),
    .id_alu_op       (id_alu_op),
    .id_src_a        (id_src_a),
    .id_src_b        (id_src_b),
    .id_store_data   (id_store_data),
    .id_op_dest      (id_op_dest),
    .id_mem_write_en (id_mem_write_en),
    .id_wb_mux       (id_wb_mux),
    .id_wb_en        (id_wb_en),
    .ex_alu_res      (ex_alu_res),
    .ex_store_data   (ex_store_data),
    .ex_op_dest      (ex_op_dest),
    .mem_write_en    (mem_write_en),
    .ex_wb_mux       (ex_wb_mux),
    .ex_wb_en        (ex_wb_en),
    .ex_busy         (ex_busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] res;
    logic [15:0] sd;
    logic [2:0]  dest;
    logic        mw;
    logic        wbm;
    logic        wbe;
  } regs_t;

  typedef struct {
    regs_t regs;  // expected after the next edge
    logic  busy;  // expected during the issue cycle
    string tag;
  } exp_t;

  exp_t  sb_q[$];
  exp_t  pend;
  logic  pend_v = 1'b0;
  int    checks = 0;
  int    errors = 0;

  logic [15:0] c_sd = '0;
  logic [2:0]  c_dest = '0;
  logic        c_mw = 1'b0, c_wbm = 1'b0, c_wbe = 1'b0;

  task automatic set_ctl(input logic [15:0] sd, input logic [2:0] dest, input logic mw,
                         input logic wbm, input logic wbe);
    c_sd = sd; c_dest = dest; c_mw = mw; c_wbm = wbm; c_wbe = wbe;
  endtask

  task automatic drive(input logic r, input logic v, input logic f, input logic [2:0] op,
                       input logic [15:0] a, input logic [15:0] b, input logic [15:0] res,
                       input logic bub, input logic busy, input string tag);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r; id_valid = v; id_flush = f; id_alu_op = op; id_src_a = a; id_src_b = b;
    id_store_data = c_sd; id_op_dest = c_dest; id_mem_write_en = c_mw;
    id_wb_mux = c_wbm; id_wb_en = c_wbe;
    if (bub) e.regs = '0;
    else     e.regs = '{res: res, sd: c_sd, dest: c_dest, mw: c_mw, wbm: c_wbm, wbe: c_wbe};
    e.busy = busy;
    e.tag  = tag;
    sb_q.push_back(e);
  endtask

  task automatic alu(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                     input logic [15:0] res, input string tag);
    drive(1'b0, 1'b1, 1'b0, op, a, b, res, 1'b0, 1'b0, tag);
  endtask

  task automatic idle(input string tag);
    drive(1'b0, 1'b0, 1'b0, ALU_ADD, 16'h0, 16'h0, 16'h0, 1'b1, 1'b0, tag);
  endtask

`ifdef EX_STAGE_MUL_EN
  task automatic mul_hold(input logic [15:0] a, input logic [15:0] b, input string tag);
    drive(1'b0, 1'b1, 1'b0, ALU_MUL, a, b, 16'h0, 1'b1, 1'b1, tag);
  endtask

  task automatic mul_run(input logic [15:0] a, input logic [15:0] b, input logic [15:0] p,
                         input string tag);
    for (int i = 0; i < 17; i++) mul_hold(a, b, tag);
    drive(1'b0, 1'b1, 1'b0, ALU_MUL, a, b, p, 1'b0, 1'b0, tag);
  endtask
`endif

  always @(negedge clk) begin
    exp_t e;
    regs_t act;
    act = '{res: ex_alu_res, sd: ex_store_data, dest: ex_op_dest, mw: mem_write_en,
            wbm: ex_wb_mux, wbe: ex_wb_en};
    if (pend_v) begin
      checks++;
      if (act !== pend.regs) begin
        errors++;
        $display("FAIL %s regs: got res=%h sd=%h dest=%0d mw=%b wbm=%b wbe=%b, want res=%h sd=%h dest=%0d mw=%b wbm=%b wbe=%b",
                 pend.tag, act.res, act.sd, act.dest, act.mw, act.wbm, act.wbe,
                 pend.regs.res, pend.regs.sd, pend.regs.dest, pend.regs.mw, pend.regs.wbm,
                 pend.regs.wbe);
      end
    end
    pend_v = 1'b0;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      checks++;
      if (ex_busy !== e.busy) begin
        errors++;
        $display("FAIL %s busy: got %b want %b", e.tag, ex_busy, e.busy);
      end
      pend   = e;
      pend_v = 1'b1;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    set_ctl(16'h0, 3'd0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0, ALU_ADD, 16'h0, 16'h0, 16'h0, 1'b1, 1'b0, "reset");
    drive(1'b1, 1'b1, 1'b0, ALU_ADD, 16'h5, 16'h5, 16'h0, 1'b1, 1'b0, "reset_valid");

    set_ctl(16'h0, 3'd3, 1'b0, 1'b0, 1'b1);
    alu(ALU_ADD, 16'h7FFF, 16'h0001, 16'h8000, "add_ovf");
    set_ctl(16'h0, 3'd5, 1'b0, 1'b0, 1'b1);
    alu(ALU_SUB, 16'h0000, 16'h0001, 16'hFFFF, "sub_wrap");
    alu(ALU_SLL, 16'h0001, 16'h0013, 16'h0008, "sll_amt4");
    alu(ALU_SRL, 16'h8000, 16'h0004, 16'h0800, "srl");
    alu(ALU_AND, 16'hF0F0, 16'h0FF0, 16'h00F0, "and");
    alu(ALU_OR,  16'hF000, 16'h000F, 16'hF00F, "or");
    alu(ALU_XOR, 16'hFFFF, 16'h00FF, 16'hFF00, "xor");
    set_ctl(16'hABCD, 3'd0, 1'b1, 1'b0, 1'b0);
    alu(ALU_ADD, 16'h1000, 16'h0020, 16'h1020, "store");
    set_ctl(16'h0, 3'd2, 1'b0, 1'b1, 1'b1);
    alu(ALU_ADD, 16'h2000, 16'h0004, 16'h2004, "load");
    drive(1'b0, 1'b0, 1'b0, ALU_ADD, 16'h1, 16'h1, 16'h0, 1'b1, 1'b0, "invalid");
    drive(1'b0, 1'b1, 1'b1, ALU_ADD, 16'h1, 16'h1, 16'h0, 1'b1, 1'b0, "flush");

`ifdef EX_STAGE_MUL_EN
    set_ctl(16'h0, 3'd4, 1'b0, 1'b0, 1'b1);
    mul_run(16'h0012, 16'h0034, 16'h03A8, "mul_a");
    set_ctl(16'h0, 3'd6, 1'b0, 1'b0, 1'b1);
    mul_run(16'h1234, 16'h0100, 16'h3400, "mul_trunc");

    set_ctl(16'h0, 3'd1, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) mul_hold(16'h0003, 16'h0003, "mul_pre_flush");
    drive(1'b0, 1'b1, 1'b1, ALU_MUL, 16'h3, 16'h3, 16'h0, 1'b1, 1'b0, "mul_flush");
    alu(ALU_ADD, 16'h0001, 16'h0001, 16'h0002, "add_after_flush");

    drive(1'b0, 1'b1, 1'b1, ALU_MUL, 16'h3, 16'h3, 16'h0, 1'b1, 1'b0, "flush_on_accept");
    idle("no_accept");

    for (int i = 0; i < 8; i++) mul_hold(16'h0005, 16'h0007, "mul_pre_rst");
    drive(1'b1, 1'b1, 1'b0, ALU_MUL, 16'h5, 16'h7, 16'h0, 1'b1, 1'b0, "mul_rst");
    idle("post_rst");
    alu(ALU_ADD, 16'h0003, 16'h0004, 16'h0007, "add_after_rst");
`else
    set_ctl(16'h0, 3'd4, 1'b0, 1'b0, 1'b1);
    alu(ALU_MUL, 16'h0012, 16'h0034, 16'h0000, "mul_off_a");
    alu(ALU_MUL, 16'h1234, 16'h0100, 16'h0000, "mul_off_b");
    alu(ALU_ADD, 16'h0001, 16'h0001, 16'h0002, "add_after_mul");
    drive(1'b1, 1'b1, 1'b0, ALU_ADD, 16'h5, 16'h7, 16'h0, 1'b1, 1'b0, "rst_mid");
    alu(ALU_ADD, 16'h0003, 16'h0004, 16'h0007, "add_after_rst");
`endif

    idle("tail0");
    idle("tail1");
    repeat (3) @(negedge clk);
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, want 0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
